// File: rtl/mem_stage.sv
// Pipeline memory stage: issues loads/stores on a valid/ready bus, stalls upstream while waiting.
// Define MEM_BYTE_ACCESS_EN for byte/halfword accesses; otherwise the stage is word-only.
module mem_stage #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteM,
   input  logic        MemWriteM,
   input  logic [1:0]  ResultSrcM,
   input  logic [2:0]  Funct3M,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [31:0] PCPlus4M,
   input  logic [4:0]  RdM,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        StallM,
   output logic        BusErrM,
   output logic        RegWriteW,
   output logic [1:0]  ResultSrcW,
   output logic [31:0] ALUResultW,
   output logic [31:0] ReadDataW,
   output logic [31:0] PCPlus4W,
   output logic [4:0]  RdW
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;
   localparam logic [7:0] TOUT_LAST = 8'(TIMEOUT - 1);

   logic [0:0]  state;
   logic [7:0]  cnt;
   logic        tout_q;
   logic        is_load;
   logic        access;
   logic        misal;
   logic        req_idle;
   logic        mis_err;
   logic        tout_hit;
   logic        bubble;
   logic [31:0] rdata_fmt;

   assign is_load = (ResultSrcM == 2'b01);
   assign access  = MemWriteM | is_load;
   assign mem_we  = MemWriteM;

`ifdef MEM_BYTE_ACCESS_EN
   logic [31:0] lane;

   assign mem_addr = ALUResultM;
   assign lane     = mem_rdata >> {ALUResultM[1:0], 3'b000};

   always_comb begin
      misal     = 1'b0;
      mem_wstrb = 4'b1111;
      mem_wdata = WriteDataM;
      case (Funct3M[1:0])
         2'b00: begin
            mem_wstrb = 4'b0001 << ALUResultM[1:0];
            mem_wdata = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            mem_wstrb = 4'b0011 << ALUResultM[1:0];
            mem_wdata = {2{WriteDataM[15:0]}};
            misal     = ALUResultM[0];
         end
         default: begin
            mem_wstrb = 4'b1111;
            mem_wdata = WriteDataM;
            misal     = |ALUResultM[1:0];
         end
      endcase
   end

   always_comb begin
      rdata_fmt = mem_rdata;
      case (Funct3M)
         3'b000:  rdata_fmt = {{24{lane[7]}}, lane[7:0]};
         3'b100:  rdata_fmt = {24'b0, lane[7:0]};
         3'b001:  rdata_fmt = {{16{lane[15]}}, lane[15:0]};
         3'b101:  rdata_fmt = {16'b0, lane[15:0]};
         default: rdata_fmt = mem_rdata;
      endcase
   end
`else
   logic unused_funct3;

   assign unused_funct3 = ^Funct3M;
   assign misal         = 1'b0;
   assign mem_addr      = {ALUResultM[31:2], 2'b00};
   assign mem_wstrb     = 4'b1111;
   assign mem_wdata     = WriteDataM;
   assign rdata_fmt     = mem_rdata;
`endif

   // tout_q marks the cycle after a timeout: M still holds the abandoned access, so it is drained
   // as a bubble instead of being re-requested.
   assign req_idle = (state == S_IDLE) & access & ~misal & ~tout_q;
   assign mis_err  = (state == S_IDLE) & access & misal & ~tout_q;
   assign tout_hit = (state == S_WAIT) & ~mem_ready & (cnt == TOUT_LAST);

   assign mem_req = rst & (req_idle | (state == S_WAIT));
   assign StallM  = rst & ~mem_ready & (req_idle | (state == S_WAIT));
   assign BusErrM = rst & (tout_q | mis_err);
   assign bubble  = StallM | tout_q | mis_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         tout_q <= 1'b0;
      end else begin
         tout_q <= tout_hit;
         case (state)
            S_IDLE: begin
               if (req_idle && !mem_ready) begin
                  state <= S_WAIT;
                  cnt   <= '0;
               end
            end
            S_WAIT: begin
               if (mem_ready || (cnt == TOUT_LAST)) begin
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWriteW  <= 1'b0;
         ResultSrcW <= '0;
         ALUResultW <= '0;
         ReadDataW  <= '0;
         PCPlus4W   <= '0;
         RdW        <= '0;
      end else if (bubble) begin
         RegWriteW  <= 1'b0;
         ResultSrcW <= '0;
         ALUResultW <= '0;
         ReadDataW  <= '0;
         PCPlus4W   <= '0;
         RdW        <= '0;
      end else begin
         RegWriteW  <= RegWriteM;
         ResultSrcW <= ResultSrcM;
         ALUResultW <= ALUResultM;
         ReadDataW  <= is_load ? rdata_fmt : 32'h0;
         PCPlus4W   <= PCPlus4M;
         RdW        <= RdM;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with TIMEOUT = 4; byte-lane checks follow MEM_BYTE_ACCESS_EN.
module tb_mem_stage;

   localparam int unsigned TIMEOUT = 4;

   logic        clk;
   logic        rst;
   logic        RegWriteM;
   logic        MemWriteM;
   logic [1:0]  ResultSrcM;
   logic [2:0]  Funct3M;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic [31:0] PCPlus4M;
   logic [4:0]  RdM;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        StallM;
   logic        BusErrM;
   logic        RegWriteW;
   logic [1:0]  ResultSrcW;
   logic [31:0] ALUResultW;
   logic [31:0] ReadDataW;
   logic [31:0] PCPlus4W;
   logic [4:0]  RdW;

   int checks = 0;
   int errors = 0;

   mem_stage #(
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .RegWriteM  (RegWriteM),
      .MemWriteM  (MemWriteM),
      .ResultSrcM (ResultSrcM),
      .Funct3M    (Funct3M),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .PCPlus4M   (PCPlus4M),
      .RdM        (RdM),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .StallM     (StallM),
      .BusErrM    (BusErrM),
      .RegWriteW  (RegWriteW),
      .ResultSrcW (ResultSrcW),
      .ALUResultW (ALUResultW),
      .ReadDataW  (ReadDataW),
      .PCPlus4W   (PCPlus4W),
      .RdW        (RdW)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: observed no finish, required finish before 50000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_m(input logic rw, input logic mw, input logic [1:0] rs,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [31:0] pc, input logic [4:0] rd);
      RegWriteM  = rw;
      MemWriteM  = mw;
      ResultSrcM = rs;
      Funct3M    = f3;
      ALUResultM = alu;
      WriteDataM = wd;
      PCPlus4M   = pc;
      RdM        = rd;
   endtask

   task automatic nop();
      set_m(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      nop();
      #12;
      chk("rst_req", {31'b0, mem_req}, 32'h0);
      chk("rst_stall", {31'b0, StallM}, 32'h0);
      chk("rst_err", {31'b0, BusErrM}, 32'h0);
      chk("rst_regw", {31'b0, RegWriteW}, 32'h0);
      chk("rst_rd", {27'b0, RdW}, 32'h0);
      chk("rst_alu", ALUResultW, 32'h0);
      chk("rst_rdata", ReadDataW, 32'h0);
      chk("rst_pc4", PCPlus4W, 32'h0);
      chk("rst_rsrc", {30'b0, ResultSrcW}, 32'h0);
      rst = 1'b1;
      tick();

      // Non-access instruction passes straight through
      set_m(1'b1, 1'b0, 2'b00, 3'b000, 32'h55, 32'h0, 32'h60, 5'd3);
      #1;
      chk("pass_req", {31'b0, mem_req}, 32'h0);
      chk("pass_stall", {31'b0, StallM}, 32'h0);
      tick();
      chk("pass_regw", {31'b0, RegWriteW}, 32'h1);
      chk("pass_rd", {27'b0, RdW}, 32'd3);
      chk("pass_alu", ALUResultW, 32'h55);
      chk("pass_pc4", PCPlus4W, 32'h60);

      // Zero-wait lw
      set_m(1'b1, 1'b0, 2'b01, 3'b010, 32'h100, 32'h0, 32'h44, 5'd5);
      mem_ready = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      #1;
      chk("lw0_req", {31'b0, mem_req}, 32'h1);
      chk("lw0_we", {31'b0, mem_we}, 32'h0);
      chk("lw0_addr", mem_addr, 32'h100);
      chk("lw0_stall", {31'b0, StallM}, 32'h0);
      tick();
      chk("lw0_rdata", ReadDataW, 32'hDEADBEEF);
      chk("lw0_rd", {27'b0, RdW}, 32'd5);
      chk("lw0_regw", {31'b0, RegWriteW}, 32'h1);
      chk("lw0_rsrc", {30'b0, ResultSrcW}, 32'h1);
      nop();
      mem_ready = 1'b0;
      #1;
      chk("lw0_noreq", {31'b0, mem_req}, 32'h0);

      // 3-wait sw
      set_m(1'b0, 1'b1, 2'b00, 3'b010, 32'h204, 32'h12345678, 32'h48, 5'd0);
      for (int i = 0; i < 4; i++) begin
         mem_ready = (i == 3);
         #1;
         chk($sformatf("sw_req%0d", i), {31'b0, mem_req}, 32'h1);
         chk($sformatf("sw_we%0d", i), {31'b0, mem_we}, 32'h1);
         chk($sformatf("sw_addr%0d", i), mem_addr, 32'h204);
         chk($sformatf("sw_wdata%0d", i), mem_wdata, 32'h12345678);
         chk($sformatf("sw_wstrb%0d", i), {28'b0, mem_wstrb}, 32'hF);
         chk($sformatf("sw_stall%0d", i), {31'b0, StallM}, (i < 3) ? 32'h1 : 32'h0);
         tick();
      end
      chk("sw_regw", {31'b0, RegWriteW}, 32'h0);
      chk("sw_pc4", PCPlus4W, 32'h48);
      chk("sw_alu", ALUResultW, 32'h204);
      nop();
      mem_ready = 1'b0;
      #1;
      chk("sw_noreq", {31'b0, mem_req}, 32'h0);
      chk("sw_nostall", {31'b0, StallM}, 32'h0);

      // Timeout: one IDLE request cycle plus four WAIT cycles, then the error cycle
      set_m(1'b1, 1'b0, 2'b01, 3'b010, 32'h300, 32'h0, 32'h50, 5'd7);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("to_req%0d", i), {31'b0, mem_req}, 32'h1);
         chk($sformatf("to_stall%0d", i), {31'b0, StallM}, 32'h1);
         chk($sformatf("to_err%0d", i), {31'b0, BusErrM}, 32'h0);
         tick();
      end
      chk("to_dropreq", {31'b0, mem_req}, 32'h0);
      chk("to_errpulse", {31'b0, BusErrM}, 32'h1);
      chk("to_release", {31'b0, StallM}, 32'h0);
      tick();
      chk("to_regw", {31'b0, RegWriteW}, 32'h0);
      chk("to_rd", {27'b0, RdW}, 32'h0);
      nop();
      #1;
      chk("to_errclr", {31'b0, BusErrM}, 32'h0);
      chk("to_noreq", {31'b0, mem_req}, 32'h0);
      tick();

      // Reset while a load is waiting
      set_m(1'b1, 1'b0, 2'b01, 3'b010, 32'h400, 32'h0, 32'h70, 5'd9);
      tick();
      chk("rw_req", {31'b0, mem_req}, 32'h1);
      chk("rw_stall", {31'b0, StallM}, 32'h1);
      rst = 1'b0;
      #1;
      chk("rw_rreq", {31'b0, mem_req}, 32'h0);
      chk("rw_rstall", {31'b0, StallM}, 32'h0);
      chk("rw_rerr", {31'b0, BusErrM}, 32'h0);
      chk("rw_rregw", {31'b0, RegWriteW}, 32'h0);
      chk("rw_rrd", {27'b0, RdW}, 32'h0);
      chk("rw_rrdata", ReadDataW, 32'h0);
      nop();
      rst = 1'b1;
      #1;
      chk("rw_idle", {31'b0, mem_req}, 32'h0);
      tick();

`ifdef MEM_BYTE_ACCESS_EN
      set_m(1'b0, 1'b1, 2'b00, 3'b000, 32'h103, 32'hAB, 32'h80, 5'd0);
      mem_ready = 1'b1;
      #1;
      chk("sb_wstrb", {28'b0, mem_wstrb}, 32'h8);
      chk("sb_wdata", mem_wdata, 32'hABABABAB);
      chk("sb_addr", mem_addr, 32'h103);
      tick();
      set_m(1'b1, 1'b0, 2'b01, 3'b000, 32'h102, 32'h0, 32'h84, 5'd10);
      mem_rdata = 32'h0080FF00;
      tick();
      chk("lb_rdata", ReadDataW, 32'hFFFFFF80);
      set_m(1'b1, 1'b0, 2'b01, 3'b101, 32'h102, 32'h0, 32'h84, 5'd10);
      tick();
      chk("lhu_rdata", ReadDataW, 32'h00000080);
      set_m(1'b1, 1'b0, 2'b01, 3'b010, 32'h101, 32'h0, 32'h88, 5'd11);
      mem_ready = 1'b0;
      #1;
      chk("mis_req", {31'b0, mem_req}, 32'h0);
      chk("mis_err", {31'b0, BusErrM}, 32'h1);
      chk("mis_stall", {31'b0, StallM}, 32'h0);
      tick();
      chk("mis_regw", {31'b0, RegWriteW}, 32'h0);
      chk("mis_rd", {27'b0, RdW}, 32'h0);
      nop();
      #1;
      chk("mis_errclr", {31'b0, BusErrM}, 32'h0);
`else
      set_m(1'b1, 1'b0, 2'b01, 3'b010, 32'h101, 32'h0, 32'h88, 5'd11);
      mem_ready = 1'b1;
      mem_rdata = 32'hCAFEF00D;
      #1;
      chk("wl_addr", mem_addr, 32'h100);
      chk("wl_req", {31'b0, mem_req}, 32'h1);
      chk("wl_err", {31'b0, BusErrM}, 32'h0);
      tick();
      chk("wl_rdata", ReadDataW, 32'hCAFEF00D);
      chk("wl_regw", {31'b0, RegWriteW}, 32'h1);
      chk("wl_rd", {27'b0, RdW}, 32'd11);
      set_m(1'b0, 1'b1, 2'b00, 3'b000, 32'h103, 32'hAB, 32'h8C, 5'd0);
      #1;
      chk("ws_wstrb", {28'b0, mem_wstrb}, 32'hF);
      chk("ws_wdata", mem_wdata, 32'hAB);
      chk("ws_addr", mem_addr, 32'h100);
      tick();
`endif

      nop();
      mem_ready = 1'b0;
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
